// File: rtl/hazard_controller_if.sv
// Data-memory side of the hazard controller: EX/MEM access type plus the
// word-level req/ready handshake used to sequence multi-word accesses.
interface hazard_controller_if;
    logic       EXMEM_MR;
    logic       EXMEM_MW;
    logic       EXMEM_Stack_PC;
    logic       Mem_Ready;
    logic       Mem_Req;
    logic [1:0] Mem_Word;

    modport master (
        input  EXMEM_MR,
        input  EXMEM_MW,
        input  EXMEM_Stack_PC,
        input  Mem_Ready,
        output Mem_Req,
        output Mem_Word
    );

    modport slave (
        output EXMEM_MR,
        output EXMEM_MW,
        output EXMEM_Stack_PC,
        output Mem_Ready,
        input  Mem_Req,
        input  Mem_Word
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer: stall/bubble/flush generation for load-use hazards and
// taken jumps, plus word sequencing of multi-word data-memory accesses.
module hazard_controller #(
    parameter int PC_WORDS = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_controller_if.master mem,
    input  logic             IDEX_MR,
    input  logic             IDEX_WB,
    input  logic [2:0]       IDEX_WB_Address,
    input  logic [2:0]       IFID_Src1,
    input  logic [2:0]       IFID_Src2,
    input  logic             IFID_Use1,
    input  logic             IFID_Use2,
    input  logic             Taken_Jump,
    output logic             PC_Stall,
    output logic             IFID_Stall,
    output logic             IFID_Flush,
    output logic             IDEX_Stall,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Stall,
    output logic             MEMWB_Bubble,
    output logic [CNT_W-1:0] Stall_Cycles
);

    localparam logic [1:0] PC_WORDS_L = 2'(PC_WORDS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;

    logic       memop;
    logic [1:0] n_words;
    logic       done;
    logic       freeze;
    logic       load_use;
    logic       mem_req;
    logic [1:0] mem_word;

    assign memop   = mem.EXMEM_MR | mem.EXMEM_MW;
    assign n_words = mem.EXMEM_Stack_PC ? PC_WORDS_L : 2'd1;

    assign load_use = IDEX_MR && IDEX_WB &&
                      ((IFID_Use1 && (IFID_Src1 == IDEX_WB_Address)) ||
                       (IFID_Use2 && (IFID_Src2 == IDEX_WB_Address)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_req   = 1'b0;
        mem_word  = '0;
        done      = 1'b0;

        unique case (state)
            IDLE: begin
                mem_req = memop;
                done    = mem.Mem_Ready && (n_words == 2'd1);
                if (memop && mem.Mem_Ready && (n_words > 2'd1)) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = 2'd1;
                end else if (memop && !mem.Mem_Ready) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                mem_req  = 1'b1;
                mem_word = cnt;
                done     = mem.Mem_Ready && (cnt == n_words - 2'd1);
                if (done) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (mem.Mem_Ready) begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign freeze = mem_req && !done;

    // Freeze outranks the jump: EX is held, so the jump is re-seen on release.
    always_comb begin
        PC_Stall     = 1'b0;
        IFID_Stall   = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Stall   = 1'b0;
        IDEX_Bubble  = 1'b0;
        EXMEM_Stall  = 1'b0;
        MEMWB_Bubble = 1'b0;
        if (!rst) begin
            if (freeze) begin
                PC_Stall     = 1'b1;
                IFID_Stall   = 1'b1;
                IDEX_Stall   = 1'b1;
                EXMEM_Stall  = 1'b1;
                MEMWB_Bubble = 1'b1;
            end else if (Taken_Jump) begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end else if (load_use) begin
                PC_Stall    = 1'b1;
                IFID_Stall  = 1'b1;
                IDEX_Bubble = 1'b1;
            end
        end
    end

    assign mem.Mem_Req  = rst ? 1'b0 : mem_req;
    assign mem.Mem_Word = rst ? '0   : mem_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (PC_Stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign Stall_Cycles = rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_controller;

    localparam int CNT_W = 6;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             IDEX_MR, IDEX_WB, IFID_Use1, IFID_Use2, Taken_Jump;
    logic [2:0]       IDEX_WB_Address, IFID_Src1, IFID_Src2;
    logic             PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Bubble;
    logic             EXMEM_Stall, MEMWB_Bubble;
    logic [CNT_W-1:0] Stall_Cycles;

    hazard_controller_if mif();

    hazard_controller #(.PC_WORDS(2), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem             (mif),
        .IDEX_MR         (IDEX_MR),
        .IDEX_WB         (IDEX_WB),
        .IDEX_WB_Address (IDEX_WB_Address),
        .IFID_Src1       (IFID_Src1),
        .IFID_Src2       (IFID_Src2),
        .IFID_Use1       (IFID_Use1),
        .IFID_Use2       (IFID_Use2),
        .Taken_Jump      (Taken_Jump),
        .PC_Stall        (PC_Stall),
        .IFID_Stall      (IFID_Stall),
        .IFID_Flush      (IFID_Flush),
        .IDEX_Stall      (IDEX_Stall),
        .IDEX_Bubble     (IDEX_Bubble),
        .EXMEM_Stall     (EXMEM_Stall),
        .MEMWB_Bubble    (MEMWB_Bubble),
        .Stall_Cycles    (Stall_Cycles)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding transaction and the words it has completed so far.
    bit busy        = 1'b0;
    int words       = 0;
    int stall_model = 0;
    bit prev_freeze = 1'b0;

    always @(negedge clk) begin
        bit         memop, lu, req, dn, frz;
        int         n, e_word, e_cnt;
        logic [6:0] e_ctrl, a_ctrl;

        memop  = mif.EXMEM_MR || mif.EXMEM_MW;
        n      = mif.EXMEM_Stack_PC ? 2 : 1;
        lu     = IDEX_MR && IDEX_WB &&
                 ((IFID_Use1 && IFID_Src1 == IDEX_WB_Address) ||
                  (IFID_Use2 && IFID_Src2 == IDEX_WB_Address));
        req    = !rst && (busy || memop);
        dn     = req && mif.Mem_Ready && (words == n - 1);
        frz    = req && !dn;
        e_word = rst ? 0 : words;
        e_cnt  = rst ? 0 : stall_model;

        // {PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Bubble, EXMEM_Stall, MEMWB_Bubble}
        if (rst)             e_ctrl = 7'b000_0000;
        else if (frz)        e_ctrl = 7'b110_1011;
        else if (Taken_Jump) e_ctrl = 7'b001_0100;
        else if (lu)         e_ctrl = 7'b110_0100;
        else                 e_ctrl = 7'b000_0000;

        a_ctrl = {PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Bubble, EXMEM_Stall, MEMWB_Bubble};
        chk("ctrl", 32'(a_ctrl), 32'(e_ctrl));
        chk("mem_req_word", {29'd0, mif.Mem_Req, mif.Mem_Word}, {29'd0, req, 2'(e_word)});
        chk("stall_cycles", 32'(Stall_Cycles), 32'(e_cnt));

        if (rst) begin
            busy        = 1'b0;
            words       = 0;
            stall_model = 0;
        end else begin
            if (e_ctrl[6] && stall_model < SAT) stall_model++;
            if (req) begin
                if (dn) begin
                    busy  = 1'b0;
                    words = 0;
                end else begin
                    busy  = 1'b1;
                    words = words + (mif.Mem_Ready ? 1 : 0);
                end
            end
        end
        prev_freeze = frz;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IDEX_MR = 0; IDEX_WB = 0; IDEX_WB_Address = 0;
        IFID_Src1 = 0; IFID_Src2 = 0; IFID_Use1 = 0; IFID_Use2 = 0;
        Taken_Jump = 0;
        mif.EXMEM_MR = 0; mif.EXMEM_MW = 0; mif.EXMEM_Stack_PC = 0; mif.Mem_Ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset held two cycles in the middle of an access
        rst = 1'b0; mif.EXMEM_MR = 1; mif.Mem_Ready = 0;
        @(negedge clk); chk("t1_req_before", 32'(mif.Mem_Req), 32'd1);
        step(); rst = 1'b1;
        @(negedge clk); chk("t1_req_in_rst", 32'(mif.Mem_Req), 32'd0);
        chk("t1_pcstall_in_rst", 32'(PC_Stall), 32'd0);
        step();
        step(); rst = 1'b0; mif.EXMEM_MR = 0;
        @(negedge clk); chk("t1_req_after", 32'(mif.Mem_Req), 32'd0);
        chk("t1_cnt_after", 32'(Stall_Cycles), 32'd0);
        chk("t1_word_after", 32'(mif.Mem_Word), 32'd0);

        // Load-use on Src2
        step(); IDEX_MR = 1; IDEX_WB = 1; IDEX_WB_Address = 3;
        IFID_Src1 = 5; IFID_Use1 = 1; IFID_Src2 = 3; IFID_Use2 = 1;
        @(negedge clk); chk("t2_pc_stall", 32'(PC_Stall), 32'd1);
        chk("t2_ifid_stall", 32'(IFID_Stall), 32'd1);
        chk("t2_idex_bubble", 32'(IDEX_Bubble), 32'd1);
        chk("t2_idex_stall", 32'(IDEX_Stall), 32'd0);
        step(); IDEX_MR = 0;
        @(negedge clk); chk("t2_pc_released", 32'(PC_Stall), 32'd0);
        chk("t2_cnt", 32'(Stall_Cycles), 32'd1);

        // Taken jump overrides load-use
        step(); IDEX_MR = 1; Taken_Jump = 1;
        @(negedge clk); chk("t3_flush", 32'(IFID_Flush), 32'd1);
        chk("t3_bubble", 32'(IDEX_Bubble), 32'd1);
        chk("t3_pc_stall", 32'(PC_Stall), 32'd0);
        step(); IDEX_MR = 0; Taken_Jump = 0;

        // Two-word stack-PC write with memory always ready
        mif.EXMEM_MW = 1; mif.EXMEM_Stack_PC = 1; mif.Mem_Ready = 1;
        @(negedge clk); chk("t4_w0_req", 32'(mif.Mem_Req), 32'd1);
        chk("t4_w0_word", 32'(mif.Mem_Word), 32'd0);
        chk("t4_w0_freeze", 32'(EXMEM_Stall), 32'd1);
        step();
        @(negedge clk); chk("t4_w1_word", 32'(mif.Mem_Word), 32'd1);
        chk("t4_w1_freeze", 32'(EXMEM_Stall), 32'd0);
        chk("t4_w1_req", 32'(mif.Mem_Req), 32'd1);
        step(); mif.EXMEM_MW = 0; mif.EXMEM_Stack_PC = 0;
        @(negedge clk); chk("t4_idle_req", 32'(mif.Mem_Req), 32'd0);
        chk("t4_cnt", 32'(Stall_Cycles), 32'd2);

        // Single-word read, memory not ready for three cycles
        step(); mif.EXMEM_MR = 1; mif.Mem_Ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t5_memwb_bubble", 32'(MEMWB_Bubble), 32'd1);
            step();
        end
        mif.Mem_Ready = 1;
        @(negedge clk); chk("t5_release", 32'(MEMWB_Bubble), 32'd0);
        chk("t5_release_req", 32'(mif.Mem_Req), 32'd1);
        step(); mif.EXMEM_MR = 0;
        @(negedge clk); chk("t5_cnt", 32'(Stall_Cycles), 32'd5);

        // Long freeze drives the counter into saturation
        step(); mif.EXMEM_MR = 1; mif.Mem_Ready = 0;
        repeat (70) step();
        mif.Mem_Ready = 1;
        step(); mif.EXMEM_MR = 0;
        @(negedge clk); chk("t6_saturated", 32'(Stall_Cycles), 32'(SAT));
        step(); IDEX_MR = 1;
        @(negedge clk); chk("t6_stall_again", 32'(PC_Stall), 32'd1);
        step(); IDEX_MR = 0;
        @(negedge clk); chk("t6_still_sat", 32'(Stall_Cycles), 32'(SAT));

        // Randomized traffic; EX/MEM and EX stay put while frozen
        step(); rst = 1'b1; clear_inputs();
        step(); rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!prev_freeze) begin
                mif.EXMEM_MR       = ($urandom_range(0, 9) < 2);
                mif.EXMEM_MW       = ($urandom_range(0, 9) < 2);
                mif.EXMEM_Stack_PC = $urandom_range(0, 1);
                Taken_Jump         = ($urandom_range(0, 9) < 2);
            end
            mif.Mem_Ready   = ($urandom_range(0, 9) < 6);
            IDEX_MR         = $urandom_range(0, 1);
            IDEX_WB         = ($urandom_range(0, 3) != 0);
            IDEX_WB_Address = 3'($urandom_range(0, 7));
            IFID_Src1       = 3'($urandom_range(0, 7));
            IFID_Src2       = 3'($urandom_range(0, 7));
            IFID_Use1       = $urandom_range(0, 1);
            IFID_Use2       = $urandom_range(0, 1);
            step();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
